// File: rtl/instr_prefetch.sv
// ---------------------------------------------------------------------------
// instr_prefetch
//   Instruction fetch stage sitting directly in front of the execute core.
//   Issues single-word reads on a req/ack memory bus (at most one outstanding),
//   buffers the returned words with their PCs in a small FIFO, and hands them
//   to the core over a valid/ready interface. A redirect (taken branch/jump)
//   flushes the buffer and restarts fetch at a new word address.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch word address after reset
//
// Ports
//   clock          in   single clock, all state changes on posedge
//   reset          in   synchronous, active-low reset
//   mem_req        out  read request to memory
//   mem_addr       out  word address of the current request
//   mem_ack        in   memory returns mem_rdata for the current request
//   mem_rdata      in   returned instruction word (used when mem_req & mem_ack)
//   instr          out  instruction at FIFO head (0 when empty)
//   instr_pc       out  word address of instr (0 when empty)
//   instr_valid    out  FIFO head is valid
//   instr_ready    in   core takes the head this cycle
//   redirect       in   flush and restart fetch
//   redirect_addr  in   new fetch address, used when redirect=1
// ---------------------------------------------------------------------------
module instr_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_addr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_after;

    logic [31:0] data_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    logic push;
    logic pop;
    logic credit;

    // A redirect voids both the pop and the push of its cycle.
    always_comb begin
        pop         = instr_valid & instr_ready & ~redirect;
        push        = (state_q == S_REQ) & mem_ack & ~redirect;
        count_after = count_q + CNT_W'(push) - CNT_W'(pop);
        // A new request is only launched when the word it returns is
        // guaranteed a slot, so the outstanding word never overflows.
        credit      = (count_after < DEPTH_C);
    end

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_after;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);

        if (redirect) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = redirect_addr;
            case (state_q)
                S_IDLE: begin
                    state_d    = S_REQ;
                    mem_addr_d = redirect_addr;
                end
                S_REQ, S_DISCARD: begin
                    if (mem_ack) begin
                        // The outstanding word completes now and is dropped,
                        // so the bus is free to go straight to the target.
                        state_d    = S_REQ;
                        mem_addr_d = redirect_addr;
                    end else begin
                        // Request still pending: keep the old address on the
                        // bus until it completes, then throw the data away.
                        state_d = S_DISCARD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (credit) begin
                        state_d    = S_REQ;
                        mem_addr_d = fetch_pc_q;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        fetch_pc_d = mem_addr_q + 32'd1;
                        mem_addr_d = mem_addr_q + 32'd1;
                        if (!credit) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DISCARD: begin
                    // FIFO is empty here (flushed by the redirect), so the
                    // target can be issued immediately.
                    if (mem_ack) begin
                        state_d    = S_REQ;
                        mem_addr_d = fetch_pc_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mem_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage is not reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (reset && push) begin
            data_mem[wr_ptr_q] <= mem_rdata;
            pc_mem[wr_ptr_q]   <= mem_addr_q;
        end
    end

    always_comb begin
        mem_req     = (state_q != S_IDLE);
        mem_addr    = mem_addr_q;
        instr_valid = (count_q != '0);
        instr       = instr_valid ? data_mem[rd_ptr_q] : 32'h0;
        instr_pc    = instr_valid ? pc_mem[rd_ptr_q]   : 32'h0;
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// ---------------------------------------------------------------------------
// tb_instr_prefetch
//   Self-checking bench for instr_prefetch: a reset/fill/credit vector table,
//   a scoreboard of expected {pc, word} pairs built from the bench's own fetch
//   address model, and hand sequences for wait states, redirect, reset and
//   address wrap (second instance with RESET_PC = 0xFFFFFFFE).
// ---------------------------------------------------------------------------
module tb_instr_prefetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_addr;

    logic        w_mem_req;
    logic [31:0] w_mem_addr;
    logic        w_mem_ack;
    logic [31:0] w_mem_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic        w_instr_valid;
    logic        w_instr_ready;
    logic        w_redirect;
    logic [31:0] w_redirect_addr;

    always #5 clock = ~clock;

    function automatic logic [31:0] model(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign mem_rdata       = model(mem_addr);
    assign w_mem_rdata     = model(w_mem_addr);
    assign w_mem_ack       = 1'b1;
    assign w_instr_ready   = 1'b1;
    assign w_redirect      = 1'b0;
    assign w_redirect_addr = 32'h0;

    instr_prefetch #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_addr(redirect_addr)
    );

    instr_prefetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFE)) dut_w (
        .clock(clock), .reset(reset),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata),
        .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
        .redirect(w_redirect), .redirect_addr(w_redirect_addr)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        ack;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int          n_pop = 0;
    int          w_idx = 0;
    int          req_age = 0;
    bit          sb_on = 0;
    bit          ack_mode = 0;
    bit          disc = 0;
    bit          stall_prev = 0;
    bit          xfer_seen = 0;
    logic [31:0] stall_addr = '0;
    logic [31:0] disc_addr = '0;
    logic [31:0] exp_next = RST_PC;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: scoreboard work at the negedge, then advance past the posedge.
    task automatic cycle();
        exp_t        e;
        logic [31:0] exp_a;
        logic [31:0] wexp;
        @(negedge clock);
        if (sb_on) begin
            if (stall_prev) begin
                chk("bus_hold_req", 32'(mem_req), 32'd1);
                chk("bus_hold_addr", mem_addr, stall_addr);
            end
            if (reset) begin
                chk("valid_vs_model", 32'(instr_valid), 32'(sb_q.size() != 0));
                if (instr_valid && instr_ready && !redirect && sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("instr_pc", instr_pc, e.pc);
                    chk("instr", instr, e.data);
                    n_pop++;
                    $display("pop pc=%h instr=%h", instr_pc, instr);
                end
                if (mem_req && mem_ack) begin
                    exp_a = disc ? disc_addr : exp_next;
                    chk("mem_addr", mem_addr, exp_a);
                    if (!redirect) begin
                        if (disc) begin
                            disc = 0;
                        end else begin
                            e.pc   = exp_next;
                            e.data = model(exp_next);
                            sb_q.push_back(e);
                            exp_next = exp_next + 32'd1;
                        end
                    end
                end
                if (redirect) begin
                    if (mem_req && !mem_ack && !disc) begin
                        disc      = 1;
                        disc_addr = exp_next;
                    end else if (mem_req && mem_ack) begin
                        disc = 0;
                    end
                    sb_q.delete();
                    exp_next = redirect_addr;
                end
                if (w_instr_valid && w_idx < 3) begin
                    wexp = 32'hFFFF_FFFE + 32'(w_idx);
                    chk("wrap_pc", w_instr_pc, wexp);
                    chk("wrap_instr", w_instr, model(wexp));
                    w_idx++;
                end
            end else begin
                sb_q.delete();
                exp_next = RST_PC;
                disc     = 0;
            end
        end
        stall_prev = sb_on && reset && mem_req && !mem_ack;
        stall_addr = mem_addr;
        xfer_seen  = reset && mem_req && mem_ack;
        @(posedge clock);
        #1;
        if (ack_mode) begin
            if (xfer_seen || !mem_req) req_age = 0;
            if (mem_req) req_age++;
            mem_ack = (req_age >= 3);
        end
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        mem_ack       = 1'b0;
        ack_mode      = 0;
        instr_ready   = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 32'h0;
        req_age       = 0;
        repeat (2) cycle();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        int   p0;
        int   k;
        bit   found;

        // ack tied 1, core stalled: reset values, 4-word fill, credit stop,
        // single pop restarting fetch at addr 4.
        //            ack   rdy   req   addr   valid pc
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 32'd1, 1'b1, 32'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 32'd2, 1'b1, 32'd0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 32'd3, 1'b1, 32'd0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 32'd4, 1'b1, 32'd1};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'd1};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'd1};

        do_reset();
        sb_on = 1;
        chk("reset_instr", instr, 32'h0);
        chk("reset_addr", mem_addr, RST_PC);
        for (int i = 0; i < 10; i++) begin
            mem_ack     = tbl[i].ack;
            instr_ready = tbl[i].ready;
            chk($sformatf("tbl%0d_req", i), 32'(mem_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid || i == 0) chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].exp_pc);
            cycle();
        end

        // Streaming: ack and ready both held high, one word per cycle.
        do_reset();
        mem_ack     = 1'b1;
        instr_ready = 1'b1;
        p0 = n_pop;
        repeat (3) cycle();
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", 32'(instr_valid), 32'd1);
            cycle();
        end
        chk("stream_pops", 32'(n_pop - p0), 32'd9);

        // Wait states: ack on the third cycle of each request.
        do_reset();
        ack_mode    = 1;
        instr_ready = 1'b1;
        p0 = n_pop;
        repeat (30) cycle();
        chk("wait_pops", 32'(n_pop - p0), 32'd9);

        // Redirect to 0x100 while the request for addr 5 is pending.
        do_reset();
        ack_mode    = 1;
        instr_ready = 1'b1;
        found = 0;
        k = 0;
        while (!found && k < 200) begin
            cycle();
            k++;
            found = mem_req && (mem_addr == 32'd5) && (req_age == 1);
        end
        chk("t4_reach", 32'(found), 32'd1);
        redirect      = 1'b1;
        redirect_addr = 32'h100;
        cycle();
        redirect = 1'b0;
        chk("t4_flush_valid", 32'(instr_valid), 32'd0);
        chk("t4_hold_req", 32'(mem_req), 32'd1);
        chk("t4_hold_addr", mem_addr, 32'd5);
        k = 0;
        while (disc && k < 20) begin
            cycle();
            k++;
        end
        chk("t4_discard_done", 32'(disc), 32'd0);
        chk("t4_target_req", 32'(mem_req), 32'd1);
        chk("t4_target_addr", mem_addr, 32'h100);
        repeat (10) cycle();

        // Redirect in the same cycle as an ack and a pop.
        do_reset();
        mem_ack = 1'b1;
        repeat (3) cycle();
        chk("t5_valid_pre", 32'(instr_valid), 32'd1);
        instr_ready   = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 32'h200;
        cycle();
        redirect = 1'b0;
        chk("t5_valid_post", 32'(instr_valid), 32'd0);
        chk("t5_req", 32'(mem_req), 32'd1);
        chk("t5_addr", mem_addr, 32'h200);
        repeat (4) cycle();

        // Reset in the middle of a pending request, then a late ack.
        do_reset();
        ack_mode = 1;
        found = 0;
        k = 0;
        while (!found && k < 200) begin
            cycle();
            k++;
            found = instr_valid && mem_req && (req_age == 1);
        end
        chk("t6_reach", 32'(found), 32'd1);
        ack_mode = 0;
        reset    = 1'b0;
        mem_ack  = 1'b1;
        cycle();
        chk("t6_req_low", 32'(mem_req), 32'd0);
        chk("t6_valid_low", 32'(instr_valid), 32'd0);
        reset       = 1'b1;
        instr_ready = 1'b1;
        cycle();
        chk("t6_restart_req", 32'(mem_req), 32'd1);
        chk("t6_restart_addr", mem_addr, RST_PC);
        repeat (5) cycle();

        chk("wrap_count", 32'(w_idx), 32'd3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
